sdf_pipe_ctrl: RTL and testbench

Sequencer for a radix-2 single-path delay-feedback (R2SDF) FFT pipeline of FFT_STAGE butterfly/delay stages, N = 2^FFT_STAGE points.
- Accepts a gapped input sample stream and issues one common stage enable plus one mux select per stage.
- Pads short frames, drains the pipeline with zero samples after the final frame, and tags output samples with frame markers and the bit-reversed bin index.
- Sits beside the stage chain at FFT top level; owns no sample data.

---
 rtl/fft_ctrl_pkg.sv | 22 ++
 rtl/sdf_tick_cnt.sv | 67 ++++++
 rtl/sdf_pipe_ctrl.sv | 112 +++++++++++
 tb/tb_sdf_pipe_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fft_ctrl_pkg.sv
// Shared types and helpers for the FFT pipeline sequencers.
package fft_ctrl_pkg;

  localparam int FFT_MAX_STAGE = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAD   = 2'd2,
    FLUSH = 2'd3
  } ctrl_state_t;

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [FFT_MAX_STAGE-1:0] bit_rev(input logic [FFT_MAX_STAGE-1:0] v,
                                                       input int w);
    logic [FFT_MAX_STAGE-1:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[i] = v[w-1-i];
    return r;
  endfunction

endpackage

// File: rtl/sdf_tick_cnt.sv
// Pipeline tick counter: owns t and the primed flag, and registers the
// per-tick stage selects and output tags.
module sdf_tick_cnt
  import fft_ctrl_pkg::*;
#(
  parameter int FFT_STAGE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 clr,
  output logic [FFT_STAGE-1:0] t,
  output logic                 stage_en,
  output logic [FFT_STAGE-1:0] stage_sel,
  output logic                 do_en,
  output logic                 do_first,
  output logic                 do_last,
  output logic [FFT_STAGE-1:0] do_idx
);

  localparam logic [FFT_STAGE-1:0] T_MAX = '1;

  logic                 primed;
  logic                 out_valid;
  logic [FFT_STAGE-1:0] out_cnt;
  logic [FFT_STAGE-1:0] sel_nxt;
  logic [FFT_STAGE-1:0] idx_nxt;

  // stage_sel[k] = t[FFT_STAGE-1-k] is simply t bit-reversed
  always_comb begin
    out_cnt   = t + 1'b1;
    out_valid = primed | (t == T_MAX);
    sel_nxt   = FFT_STAGE'(bit_rev(FFT_MAX_STAGE'(t), FFT_STAGE));
    idx_nxt   = FFT_STAGE'(bit_rev(FFT_MAX_STAGE'(out_cnt), FFT_STAGE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t         <= '0;
      primed    <= 1'b0;
      stage_en  <= 1'b0;
      stage_sel <= '0;
      do_en     <= 1'b0;
      do_first  <= 1'b0;
      do_last   <= 1'b0;
      do_idx    <= '0;
    end else begin
      stage_en <= tick;
      do_en    <= tick & out_valid;
      do_first <= tick & out_valid & (out_cnt == '0);
      do_last  <= tick & out_valid & (out_cnt == T_MAX);
      if (tick) begin
        stage_sel <= sel_nxt;
        do_idx    <= idx_nxt;
      end
      // the closing flush tick still decodes from t; only the counter restarts
      if (clr) begin
        t      <= '0;
        primed <= 1'b0;
      end else if (tick) begin
        t <= out_cnt;
        if (t == T_MAX) primed <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdf_pipe_ctrl.sv
// Sequencer for a radix-2 SDF FFT pipeline: issues stage ticks and selects,
// pads short frames, drains the pipe and tags outputs with bin indices.
//
// state | meaning
// IDLE  | no frame in flight, t = 0, waiting for first sample
// RUN   | one tick per input sample
// PAD   | zero ticks every cycle until the frame's t = N-1 tick issues
// FLUSH | N-1 zero ticks every cycle to drain the delay lines
module sdf_pipe_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int FFT_STAGE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 di_en,
  input  logic                 di_last,
  output logic                 stage_en,
  output logic [FFT_STAGE-1:0] stage_sel,
  output logic                 zero_in,
  output logic                 do_en,
  output logic                 do_first,
  output logic                 do_last,
  output logic [FFT_STAGE-1:0] do_idx,
  output logic                 busy,
  output logic                 err_misalign,
  output logic                 err_overrun
);

  localparam logic [FFT_STAGE-1:0] T_MAX       = '1;
  localparam logic [FFT_STAGE-1:0] T_FLUSH_END = T_MAX - 1'b1;

  ctrl_state_t          state;
  ctrl_state_t          state_nxt;
  logic                 tick;
  logic                 clr;
  logic                 misalign_nxt;
  logic                 overrun_nxt;
  logic [FFT_STAGE-1:0] t;

  always_comb begin
    state_nxt    = state;
    tick         = 1'b0;
    clr          = 1'b0;
    misalign_nxt = 1'b0;
    overrun_nxt  = 1'b0;
    case (state)
      IDLE, RUN: begin
        if (di_en) begin
          tick      = 1'b1;
          state_nxt = RUN;
          if (di_last) begin
            if (t == T_MAX) begin
              state_nxt = FLUSH;
            end else begin
              state_nxt    = PAD;
              misalign_nxt = 1'b1;
            end
          end
        end
      end
      PAD: begin
        tick        = 1'b1;
        overrun_nxt = di_en;
        if (t == T_MAX) state_nxt = FLUSH;
      end
      FLUSH: begin
        // flush always starts at t = 0, so t = N-2 marks the (N-1)th tick
        tick        = 1'b1;
        overrun_nxt = di_en;
        if (t == T_FLUSH_END) begin
          state_nxt = IDLE;
          clr       = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      zero_in      <= 1'b0;
      err_misalign <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      state        <= state_nxt;
      zero_in      <= tick & ((state == PAD) | (state == FLUSH));
      err_misalign <= misalign_nxt;
      err_overrun  <= overrun_nxt;
    end
  end

  assign busy = (state != IDLE);

  sdf_tick_cnt #(
    .FFT_STAGE(FFT_STAGE)
  ) u_tick_cnt (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .clr      (clr),
    .t        (t),
    .stage_en (stage_en),
    .stage_sel(stage_sel),
    .do_en    (do_en),
    .do_first (do_first),
    .do_last  (do_last),
    .do_idx   (do_idx)
  );

endmodule

// File: tb/tb_sdf_pipe_ctrl.sv
// Directed bench for sdf_pipe_ctrl with FFT_STAGE = 4 (N = 16).
module tb_sdf_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       di_en;
  logic       di_last;
  logic       stage_en;
  logic [3:0] stage_sel;
  logic       zero_in;
  logic       do_en;
  logic       do_first;
  logic       do_last;
  logic [3:0] do_idx;
  logic       busy;
  logic       err_misalign;
  logic       err_overrun;

  int         n_tests = 0;
  int         n_fail = 0;
  int         n_last = 0;
  logic [3:0] last_sel;
  logic [3:0] last_idx;

  always #5 clk = ~clk;

  sdf_pipe_ctrl #(
    .FFT_STAGE(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .di_en       (di_en),
    .di_last     (di_last),
    .stage_en    (stage_en),
    .stage_sel   (stage_sel),
    .zero_in     (zero_in),
    .do_en       (do_en),
    .do_first    (do_first),
    .do_last     (do_last),
    .do_idx      (do_idx),
    .busy        (busy),
    .err_misalign(err_misalign),
    .err_overrun (err_overrun)
  );

  function automatic logic [3:0] rev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drive one cycle of inputs, then look at the registered response
  task automatic cyc(input logic en, input logic last);
    di_en   = en;
    di_last = last;
    @(posedge clk);
    #1;
  endtask

  // expected tick k of a session: t = k mod 16, primed once k >= 16
  task automatic tick_chk(input string tag, input int k, input logic zin);
    logic [3:0]  tt;
    logic [3:0]  oc;
    logic        den;
    logic [31:0] exp;
    logic [31:0] obs;
    tt  = k[3:0];
    oc  = tt + 4'd1;
    den = (k >= 16) || (tt == 4'd15);
    exp = {19'd0, 1'b1, zin, den, den && (oc == 4'd0), den && (oc == 4'd15), rev4(tt), rev4(oc)};
    obs = {19'd0, stage_en, zero_in, do_en, do_first, do_last, stage_sel, do_idx};
    chk($sformatf("%s_tick%0d", tag, k), obs, exp);
    last_sel = rev4(tt);
    last_idx = rev4(oc);
    if (do_last) n_last++;
  endtask

  task automatic gap_chk(input string tag);
    chk({tag, "_gap_ctl"}, {27'd0, stage_en, zero_in, do_en, do_first, do_last}, 32'd0);
    chk({tag, "_gap_hold"}, {24'd0, stage_sel, do_idx}, {24'd0, last_sel, last_idx});
  endtask

  task automatic idle_chk(input string tag);
    chk(tag, {24'd0, stage_en, zero_in, do_en, do_first, do_last, busy, err_misalign, err_overrun},
        32'd0);
  endtask

  initial begin
    logic [3:0] idx_seq[16];
    idx_seq = '{4'd0, 4'd8, 4'd4, 4'd12, 4'd2, 4'd10, 4'd6, 4'd14,
                4'd1, 4'd9, 4'd5, 4'd13, 4'd3, 4'd11, 4'd7, 4'd15};
    rst     = 1'b1;
    di_en   = 1'b0;
    di_last = 1'b0;

    // reset held with di_en high
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0);
      idle_chk($sformatf("rst_flags%0d", i));
      chk("rst_sel_idx", {24'd0, stage_sel, do_idx}, 32'd0);
    end
    rst = 1'b0;

    // single continuous frame; first tick appears one cycle after rst falls
    n_last = 0;
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, k == 15);
      tick_chk("sf", k, 1'b0);
      if (k == 0) chk("sf_busy", {31'd0, busy}, 32'd1);
      if (k == 7) chk("sf_sel0_lo", {31'd0, stage_sel[0]}, 32'd0);
      if (k == 8) chk("sf_sel0_hi", {31'd0, stage_sel[0]}, 32'd1);
      if (k == 15) chk("sf_no_misalign", {31'd0, err_misalign}, 32'd0);
      if (k >= 15) chk($sformatf("sf_idx%0d", k), {28'd0, do_idx}, {28'd0, idx_seq[k-15]});
    end
    for (int k = 16; k < 31; k++) begin
      cyc(1'b0, 1'b0);
      tick_chk("sf", k, 1'b1);
      chk($sformatf("sf_idx%0d", k), {28'd0, do_idx}, {28'd0, idx_seq[k-15]});
    end
    cyc(1'b0, 1'b0);
    idle_chk("sf_end");
    chk("sf_nlast", n_last, 32'd1);

    // gapped input: 1 cycle on, 2 off
    for (int s = 0; s < 16; s++) begin
      cyc(1'b1, s == 15);
      tick_chk("gap", s, 1'b0);
      if (s < 15) begin
        for (int g = 0; g < 2; g++) begin
          cyc(1'b0, 1'b0);
          gap_chk($sformatf("gap%0d_%0d", s, g));
        end
      end
    end
    for (int k = 16; k < 31; k++) begin
      cyc(1'b0, 1'b0);
      tick_chk("gap", k, 1'b1);
    end
    cyc(1'b0, 1'b0);
    idle_chk("gap_end");

    // short frame: di_last on the 6th sample forces padding
    n_last = 0;
    for (int s = 0; s < 6; s++) begin
      cyc(1'b1, s == 5);
      tick_chk("short", s, 1'b0);
    end
    chk("short_misalign", {31'd0, err_misalign}, 32'd1);
    for (int k = 6; k < 31; k++) begin
      cyc(1'b0, 1'b0);
      tick_chk("short", k, 1'b1);
      if (k == 6) chk("short_misalign_clr", {31'd0, err_misalign}, 32'd0);
    end
    cyc(1'b0, 1'b0);
    idle_chk("short_end");
    chk("short_nlast", n_last, 32'd1);

    // two back-to-back frames never flush between them
    for (int k = 0; k < 32; k++) begin
      cyc(1'b1, k == 31);
      tick_chk("b2b", k, 1'b0);
    end
    for (int k = 32; k < 47; k++) begin
      cyc(1'b0, 1'b0);
      tick_chk("b2b", k, 1'b1);
    end
    cyc(1'b0, 1'b0);
    idle_chk("b2b_end");

    // overrun during flush, then reset mid-flush
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, k == 15);
      tick_chk("ovr", k, 1'b0);
    end
    for (int k = 16; k < 24; k++) begin
      cyc(k == 19, 1'b0);
      tick_chk("ovr", k, 1'b1);
      chk($sformatf("ovr_pulse%0d", k), {31'd0, err_overrun}, {31'd0, k == 19});
    end
    rst = 1'b1;
    cyc(1'b0, 1'b0);
    idle_chk("ovr_rst");
    chk("ovr_rst_sel_idx", {24'd0, stage_sel, do_idx}, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      cyc(1'b1, k == 15);
      tick_chk("restart", k, 1'b0);
    end
    for (int k = 16; k < 31; k++) begin
      cyc(1'b0, 1'b0);
      tick_chk("restart", k, 1'b1);
    end
    cyc(1'b0, 1'b0);
    idle_chk("restart_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
